// File: rtl/icache_pkg.sv
// Shared types and field-width helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {IDLE, REFILL} stateT;

  localparam int WORD_BYTES = 4;

  function automatic int offbits(input int wordsPerLine);
    return $clog2(wordsPerLine);
  endfunction

  function automatic int idxbits(input int numLines);
    return $clog2(numLines);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage: combinational read by index, synchronous writes and clear-all.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = idxbits(NUM_LINES),
  parameter int OFF_W          = offbits(WORDS_PER_LINE),
  parameter int TAG_W          = 32 - IDX_W - OFF_W - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clearAll,
  input  logic [IDX_W-1:0] rdIdx,
  input  logic [OFF_W-1:0] rdOff,
  output logic             rdValid,
  output logic [TAG_W-1:0] rdTag,
  output logic [31:0]      rdWord,
  input  logic             wordWe,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [OFF_W-1:0] wrOff,
  input  logic [31:0]      wrWord,
  input  logic             tagWe,
  input  logic [TAG_W-1:0] wrTag,
  input  logic             wrValid
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tagArr  [NUM_LINES];
  logic [31:0]          dataArr [NUM_LINES][WORDS_PER_LINE];

  assign rdValid = valid[rdIdx];
  assign rdTag   = tagArr[rdIdx];
  assign rdWord  = dataArr[rdIdx][rdOff];

  always_ff @(posedge clk) begin
    if (reset || clearAll) begin
      valid <= '0;
    end else if (tagWe) begin
      valid[wrIdx] <= wrValid;
    end
  end

  // Tag and data arrays carry no reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (wordWe) dataArr[wrIdx][wrOff] <= wrWord;
    if (tagWe) tagArr[wrIdx] <= wrTag;
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with line refill over a req/ready port.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_dm
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        stallF,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int BYTE_W = $clog2(WORD_BYTES);
  localparam int OFF_W  = offbits(WORDS_PER_LINE);
  localparam int IDX_W  = idxbits(NUM_LINES);
  localparam int TAG_W  = 32 - IDX_W - OFF_W - BYTE_W;
  localparam logic [31:0] LINE_MASK = 32'(WORDS_PER_LINE * WORD_BYTES - 1);

  stateT             state, stateNext;
  logic [OFF_W-1:0]  beatCnt;
  logic              poison;
  logic [31:0]       baseAddr;
  logic              lineValid;
  logic [TAG_W-1:0]  lineTag;
  logic [31:0]       lineWord;
  logic              hit, accept, lastBeat;
  logic [1:0]        unusedPcBits;

  wire [OFF_W-1:0] pcOff   = pcF[BYTE_W +: OFF_W];
  wire [IDX_W-1:0] pcIdx   = pcF[BYTE_W + OFF_W +: IDX_W];
  wire [TAG_W-1:0] pcTag   = pcF[31 -: TAG_W];
  wire [IDX_W-1:0] baseIdx = baseAddr[BYTE_W + OFF_W +: IDX_W];
  wire [TAG_W-1:0] baseTag = baseAddr[31 -: TAG_W];

  assign unusedPcBits = pcF[1:0];

  assign hit      = (state == IDLE) && !reset && !flush && lineValid && (lineTag == pcTag);
  assign accept   = (state == REFILL) && mem_ready;
  assign lastBeat = (beatCnt == OFF_W'(WORDS_PER_LINE - 1));

  icache_line_store #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W),
    .OFF_W          (OFF_W),
    .TAG_W          (TAG_W)
  ) lineStore (
    .clk      (clk),
    .reset    (reset),
    .clearAll (flush),
    .rdIdx    (pcIdx),
    .rdOff    (pcOff),
    .rdValid  (lineValid),
    .rdTag    (lineTag),
    .rdWord   (lineWord),
    .wordWe   (accept),
    .wrIdx    (baseIdx),
    .wrOff    (beatCnt),
    .wrWord   (mem_rdata),
    .tagWe    (accept && lastBeat),
    .wrTag    (baseTag),
    .wrValid  (!poison && !flush)
  );

  always_comb begin
    stateNext = state;
    instrF    = '0;
    stallF    = 1'b1;
    mem_req   = 1'b0;
    mem_addr  = '0;
    case (state)
      IDLE: begin
        stallF = ~hit;
        if (hit) instrF = lineWord;
        else     stateNext = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = baseAddr | (32'(beatCnt) << BYTE_W);
        if (accept && lastBeat) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      beatCnt <= '0;
      poison  <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE) begin
        if (!hit) begin
          beatCnt <= '0;
          poison  <= 1'b0;
        end
      end else begin
        if (accept) beatCnt <= beatCnt + 1'b1;
        // A flush during refill must outlive the refill so the line stays invalid.
        if (accept && lastBeat) poison <= 1'b0;
        else if (flush)         poison <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && !hit) baseAddr <= pcF & ~LINE_MASK;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != '1) hit_count <= hit_count + 1'b1;
      if (state == IDLE && !hit && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: bench acts as main memory and predicts hits with a line-level model.
module tb_icache_dm;

  localparam int NL  = 16;
  localparam int WPL = 4;
  localparam int LB  = WPL * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pcF = '0;
  logic        flush = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instrF;
  logic        stallF;
  logic        mem_req;
  logic [31:0] mem_addr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_dm #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .clk       (clk),
    .reset     (reset),
    .pcF       (pcF),
    .instrF    (instrF),
    .stallF    (stallF),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int          failed = 0;
  bit          mValid [NL];
  logic [31:0] mTag   [NL];
  int          expHits = 0;
  int          expMisses = 0;
  int          lastStalls = 0;
  logic [31:0] lastInstr = '0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a + 32'hA000_0000;
  endfunction

  function automatic int lineOf(input logic [31:0] a);
    return int'((a / LB) % NL);
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] a);
    return a / (LB * NL);
  endfunction

  function automatic bit modelHit(input logic [31:0] a);
    return mValid[lineOf(a)] && (mTag[lineOf(a)] == tagOf(a));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    foreach (mValid[i]) mValid[i] = 1'b0;
  endtask

  task automatic checkStats();
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, 32'(expHits));
    check("miss_count", miss_count, 32'(expMisses));
`endif
  endtask

  // Called one step after the edge that entered refill; serves WPL beats as memory.
  task automatic serveRefill(input logic [31:0] pc, input int waits, input int flushBeat,
                             output int stalls);
    logic [31:0] base, addr;
    bit          poisoned;
    int          w;
    poisoned = 1'b0;
    base     = pc & ~32'(LB - 1);
    stalls   = 1;
    for (int b = 0; b < WPL; b++) begin
      addr = base + 32'(b * 4);
      w    = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
      for (int i = 0; i < w; i++) begin
        mem_ready = 1'b0;
        pcF       = $urandom;
        @(negedge clk);
        check("wait_req", 32'(mem_req), 32'd1);
        check("wait_addr", mem_addr, addr);
        check("wait_stall", 32'(stallF), 32'd1);
        stalls++;
        @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      mem_rdata = memWord(addr);
      flush     = (b == flushBeat);
      pcF       = $urandom;
      @(negedge clk);
      check("beat_req", 32'(mem_req), 32'd1);
      check("beat_addr", mem_addr, addr);
      check("beat_stall", 32'(stallF), 32'd1);
      stalls++;
      @(posedge clk); #1;
      if (flush) poisoned = 1'b1;
      mem_ready = 1'b0;
      flush     = 1'b0;
    end
    pcF = pc;
    if (poisoned) begin
      clearModel();
    end else begin
      mValid[lineOf(pc)] = 1'b1;
      mTag[lineOf(pc)]   = tagOf(pc);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input int waits, input int flushBeat);
    bit hitExp;
    pcF       = pc;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    hitExp    = modelHit(pc);
    @(negedge clk);
    check("stallF", 32'(stallF), 32'(!hitExp));
    check("instrF", instrF, hitExp ? memWord(pc & ~32'd3) : 32'd0);
    check("idle_req", 32'(mem_req), 32'd0);
    lastInstr = instrF;
    if (hitExp) expHits++;
    else        expMisses++;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (!hitExp) serveRefill(pc, waits, flushBeat, lastStalls);
  endtask

  task automatic flushIdle(input logic [31:0] pc);
    pcF   = pc;
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", 32'(stallF), 32'd1);
    check("flush_idle_instr", instrF, 32'd0);
    expMisses++;
    @(posedge clk); #1;
    flush = 1'b0;
    clearModel();
    serveRefill(pc, -1, -1, lastStalls);
  endtask

  initial begin
    logic [31:0] pc;
    int          r;
    clearModel();
    foreach (mTag[i]) mTag[i] = '0;

    @(posedge clk); #1;
    @(negedge clk);
    check("rst_stall", 32'(stallF), 32'd1);
    check("rst_instr", instrF, 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    checkStats();

    fetch(32'h10, 0, -1);
    check("cold_stalls", 32'(lastStalls), 32'd5);
    fetch(32'h10, 0, -1);
    check("cold_instr", lastInstr, 32'hA000_0010);
    fetch(32'h14, 0, -1);
    check("hit_14", lastInstr, 32'hA000_0014);
    fetch(32'h1C, 0, -1);
    check("hit_1c", lastInstr, 32'hA000_001C);

    fetch(32'h110, 0, -1);
    check("evict_stalls", 32'(lastStalls), 32'd5);
    fetch(32'h10, 0, -1);
    check("evict_remiss", 32'(lastStalls), 32'd5);
    fetch(32'h10, 0, -1);

    fetch(32'h40, 3, -1);
    check("wait_stalls", 32'(lastStalls), 32'd17);
    fetch(32'h44, 0, -1);
    check("wait_data", lastInstr, 32'hA000_0044);

    fetch(32'h80, 0, 2);
    lastStalls = 0;
    fetch(32'h80, 0, -1);
    check("poison_refill", 32'(lastStalls), 32'd5);
    fetch(32'h84, 0, -1);
    check("poison_data", lastInstr, 32'hA000_0084);

    flushIdle(32'h80);
    fetch(32'h88, 0, -1);
    checkStats();

    for (int n = 0; n < 80; n++) begin
      r  = int'($urandom_range(0, 9));
      pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 15)) << 4)
         | (32'($urandom_range(0, 3)) << 2);
      if (r == 0) flushIdle(pc);
      else        fetch(pc, -1, (r == 1) ? int'($urandom_range(0, 3)) : -1);
    end
    checkStats();

    fetch(32'h10, 0, -1);
    pcF = 32'h310;
    @(negedge clk);
    check("pre_rst_stall", 32'(stallF), 32'd1);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    mem_rdata = memWord(32'h310);
    @(posedge clk); #1;
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    pcF   = 32'h10;
    clearModel();
    expHits   = 0;
    expMisses = 0;
    @(negedge clk);
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_stall", 32'(stallF), 32'd1);
    check("midrst_instr", instrF, 32'd0);
    checkStats();
    expMisses++;
    @(posedge clk); #1;
    serveRefill(32'h10, 0, -1, lastStalls);
    fetch(32'h10, 0, -1);
    check("post_rst_hit", lastInstr, 32'hA000_0010);
    checkStats();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
